// File: rtl/audio_frame_buffer.sv
// Ping-pong frame collector feeding fft_64: fills one bank while the other is presented
// on time_samples, and hands a completed frame over only when the FFT is free.
module audio_frame_buffer #(
  parameter int WIDTH = 12,
  parameter int N     = 64,
  parameter int DECIM = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             done,
  input  logic             overrun_clr,
  output logic             start,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  output logic             overrun,
  output logic [CNT_W-1:0] frame_count,
  output logic             fsm_state
);

  localparam int IDX_W = $clog2(N);
  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  // Handshake: start stays high for the whole time a frame is owned by the FFT;
  // a frame is released by done=1 on a rising edge while start=1.
  logic             state;
  logic [IDX_W-1:0] wr_idx;
  logic [DEC_W-1:0] dec_cnt;
  logic             wr_bank;
  logic             rd_bank;
  logic [WIDTH-1:0] bank0 [0:N-1];
  logic [WIDTH-1:0] bank1 [0:N-1];

  logic accept;
  logic complete;
  logic consumer_free;
  logic handoff;
  logic drop;

  assign accept        = sample_valid && (dec_cnt == '0);
  assign complete      = accept && (wr_idx == IDX_W'(N - 1));
  assign consumer_free = (state == IDLE) || done;
  assign handoff       = complete && consumer_free;
  assign drop          = complete && !consumer_free;

  assign start     = (state == BUSY);
  assign fsm_state = state;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      time_samples[i] = rd_bank ? bank1[i] : bank0[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_cnt <= '0;
    end else if (sample_valid) begin
      dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
    end
  end

  // wr_idx wraps naturally at N because N is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx <= '0;
      for (int i = 0; i < N; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (accept) begin
      wr_idx <= wr_idx + 1'b1;
      if (wr_bank) bank1[wr_idx] <= sample_in;
      else         bank0[wr_idx] <= sample_in;
    end
  end

  // On a dropped frame the write bank is simply reused, so the read bank stays intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b1;
      frame_count <= '0;
    end else if (handoff) begin
      rd_bank     <= wr_bank;
      wr_bank     <= ~wr_bank;
      frame_count <= frame_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (handoff) begin
      state <= BUSY;
    end else if ((state == BUSY) && done) begin
      state <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: a default instance (DECIM=1) and a
// decimating instance (DECIM=2, CNT_W=2) for decimation and frame_count wrap.
module tb_audio_frame_buffer;

  localparam int WIDTH = 12;
  localparam int N     = 64;

  logic             clk;
  logic             rst;

  logic             sample_valid;
  logic [WIDTH-1:0] sample_in;
  logic             done;
  logic             overrun_clr;
  logic             start;
  logic [WIDTH-1:0] time_samples [0:N-1];
  logic             overrun;
  logic [15:0]      frame_count;
  logic             fsm_state;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_in;
  logic             s2_done;
  logic             s2_clr;
  logic             s2_start;
  logic [WIDTH-1:0] s2_ts [0:N-1];
  logic             s2_overrun;
  logic [1:0]       s2_fc;
  logic             s2_state;

  int total;
  int bad;

  audio_frame_buffer #(.WIDTH(WIDTH), .N(N), .DECIM(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .done(done), .overrun_clr(overrun_clr), .start(start),
    .time_samples(time_samples), .overrun(overrun), .frame_count(frame_count),
    .fsm_state(fsm_state)
  );

  audio_frame_buffer #(.WIDTH(WIDTH), .N(N), .DECIM(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sample_valid(s2_valid), .sample_in(s2_in),
    .done(s2_done), .overrun_clr(s2_clr), .start(s2_start),
    .time_samples(s2_ts), .overrun(s2_overrun), .frame_count(s2_fc),
    .fsm_state(s2_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drivers: inputs change on the falling edge, outputs are read there too
  task automatic send1(input int v, input logic d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_in    = WIDTH'(v);
    done         = d;
  endtask

  task automatic idle1();
    @(negedge clk);
    sample_valid = 1'b0;
    done         = 1'b0;
    overrun_clr  = 1'b0;
  endtask

  task automatic send2(input int v, input logic d, input logic c);
    @(negedge clk);
    s2_valid = 1'b1;
    s2_in    = WIDTH'(v);
    s2_done  = d;
    s2_clr   = c;
  endtask

  task automatic idle2();
    @(negedge clk);
    s2_valid = 1'b0;
    s2_done  = 1'b0;
    s2_clr   = 1'b0;
  endtask

  task automatic test_reset();
    int errs;
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", start); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++;
    if (frame_count !== 16'd0) begin bad++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
    total++;
    if (fsm_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", fsm_state); end
    errs = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== '0) errs++;
    total++;
    if (errs != 0) begin bad++; $display("FAIL reset_samples nonzero_count=%0d exp=0", errs); end
    total++;
    if (s2_start !== 1'b0 || s2_fc !== 2'd0) begin
      bad++; $display("FAIL reset_dut2 start=%b fc=%0d exp start=0 fc=0", s2_start, s2_fc);
    end
  endtask

  task automatic test_idle_done();
    @(negedge clk);
    done = 1'b1;
    idle1();
    total++;
    if (start !== 1'b0 || frame_count !== 16'd0) begin
      bad++; $display("FAIL idle_done start=%b fc=%0d exp start=0 fc=0", start, frame_count);
    end
  endtask

  task automatic test_basic();
    int errs, first;
    for (int k = 0; k < 63; k++) send1(k, 1'b0);
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL basic_early_start got=%b exp=0", start); end
    send1(63, 1'b0);
    idle1();
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", start); end
    total++;
    if (frame_count !== 16'd1) begin bad++; $display("FAIL basic_frame_count got=%0d exp=1", frame_count); end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== WIDTH'(k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL basic_frame idx=%0d got=%0d exp=%0d", first, time_samples[first], first);
    end
  endtask

  task automatic test_async_reset();
    int errs;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    errs = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== '0) errs++;
    total++;
    if (start !== 1'b0 || overrun !== 1'b0 || frame_count !== 16'd0 || errs != 0) begin
      bad++;
      $display("FAIL async_reset start=%b overrun=%b fc=%0d nonzero=%0d exp 0/0/0/0",
               start, overrun, frame_count, errs);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_gaps();
    int errs, first;
    for (int k = 0; k < 63; k++) begin
      send1(k, 1'b0);
      idle1();
      idle1();
    end
    send1(63, 1'b0);
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL gaps_early_start got=%b exp=0", start); end
    idle1();
    total++;
    if (start !== 1'b1 || frame_count !== 16'd1) begin
      bad++; $display("FAIL gaps_start start=%b fc=%0d exp start=1 fc=1", start, frame_count);
    end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== WIDTH'(k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL gaps_frame idx=%0d got=%0d exp=%0d", first, time_samples[first], first);
    end
  endtask

  task automatic test_overrun();
    int errs, first;
    for (int k = 64; k < 128; k++) send1(k, 1'b0);
    idle1();
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    total++;
    if (frame_count !== 16'd1 || start !== 1'b1) begin
      bad++; $display("FAIL overrun_hold fc=%0d start=%b exp fc=1 start=1", frame_count, start);
    end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== WIDTH'(k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL overrun_read_bank idx=%0d got=%0d exp=%0d", first, time_samples[first], first);
    end
    @(negedge clk);
    done = 1'b1;
    idle1();
    total++;
    if (start !== 1'b0 || overrun !== 1'b1) begin
      bad++; $display("FAIL done_release start=%b overrun=%b exp start=0 overrun=1", start, overrun);
    end
    for (int k = 128; k < 192; k++) send1(k, 1'b0);
    idle1();
    total++;
    if (frame_count !== 16'd2 || start !== 1'b1) begin
      bad++; $display("FAIL second_frame fc=%0d start=%b exp fc=2 start=1", frame_count, start);
    end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== WIDTH'(128 + k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL second_frame_data idx=%0d got=%0d exp=%0d", first, time_samples[first], 128 + first);
    end
    @(negedge clk);
    overrun_clr = 1'b1;
    idle1();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
  endtask

  task automatic test_back_to_back();
    int errs, first;
    for (int k = 192; k < 255; k++) send1(k, 1'b0);
    send1(255, 1'b1);
    idle1();
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL coincident_overrun got=%b exp=0", overrun); end
    total++;
    if (start !== 1'b1 || frame_count !== 16'd3) begin
      bad++; $display("FAIL coincident_handoff start=%b fc=%0d exp start=1 fc=3", start, frame_count);
    end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (time_samples[k] !== WIDTH'(192 + k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL coincident_data idx=%0d got=%0d exp=%0d", first, time_samples[first], 192 + first);
    end
    @(negedge clk);
    done = 1'b1;
    idle1();
    total++;
    if (start !== 1'b0) begin bad++; $display("FAIL coincident_release got=%b exp=0", start); end
  endtask

  task automatic test_decim();
    int errs, first;
    for (int k = 0; k < 127; k++) send2(k, 1'b0, 1'b0);
    total++;
    if (s2_start !== 1'b0) begin bad++; $display("FAIL decim_early_start got=%b exp=0", s2_start); end
    send2(127, 1'b0, 1'b0);
    idle2();
    total++;
    if (s2_start !== 1'b1 || s2_fc !== 2'd1) begin
      bad++; $display("FAIL decim_start start=%b fc=%0d exp start=1 fc=1", s2_start, s2_fc);
    end
    errs = 0; first = 0;
    for (int k = 0; k < N; k++) if (s2_ts[k] !== WIDTH'(2 * k)) begin
      if (errs == 0) first = k;
      errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL decim_frame idx=%0d got=%0d exp=%0d", first, s2_ts[first], 2 * first);
    end
    // the frame-completing sample (254) arrives with overrun_clr high
    for (int k = 128; k < 254; k++) send2(k, 1'b0, 1'b0);
    send2(254, 1'b0, 1'b1);
    send2(255, 1'b0, 1'b0);
    idle2();
    total++;
    if (s2_overrun !== 1'b1) begin bad++; $display("FAIL decim_set_wins got=%b exp=1", s2_overrun); end
    total++;
    if (s2_fc !== 2'd1 || s2_ts[10] !== WIDTH'(20)) begin
      bad++; $display("FAIL decim_discard fc=%0d ts10=%0d exp fc=1 ts10=20", s2_fc, s2_ts[10]);
    end
  endtask

  task automatic test_count_wrap();
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      s2_done = 1'b1;
      idle2();
      for (int k = 0; k < 128; k++) send2(500 + f * 128 + k, 1'b0, 1'b0);
      idle2();
      if (f == 0) begin
        total++;
        if (s2_fc !== 2'd2) begin bad++; $display("FAIL wrap_fc2 got=%0d exp=2", s2_fc); end
      end
    end
    total++;
    if (s2_fc !== 2'd0 || s2_start !== 1'b1) begin
      bad++; $display("FAIL wrap_fc0 fc=%0d start=%b exp fc=0 start=1", s2_fc, s2_start);
    end
    total++;
    if (s2_ts[3] !== WIDTH'(500 + 256 + 6)) begin
      bad++; $display("FAIL wrap_frame_data got=%0d exp=%0d", s2_ts[3], 500 + 256 + 6);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    sample_valid = 1'b0; sample_in = '0; done = 1'b0; overrun_clr = 1'b0;
    s2_valid = 1'b0; s2_in = '0; s2_done = 1'b0; s2_clr = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    test_idle_done();
    test_basic();
    test_async_reset();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_decim();
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
